// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port between NUM_REQ requesters.
// The winner's fields are latched at grant; start is held until done, then released before the next grant.
//
// state   | meaning
// IDLE    | no transaction; pick the next requester round-robin from last+1
// ISSUE   | m_start high with latched command; wait for m_done
// RELEASE | m_start low; wait for m_done to drop before a new grant
module axi_lite_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [ID_W-1:0]           gnt_id,
    output logic                      busy,
    output logic                      m_start,
    output logic                      m_we,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic                 m_start_q, m_start_d;
    logic                 m_we_q, m_we_d;
    logic [ADDR_W-1:0]    m_addr_q, m_addr_d;
    logic [DATA_W-1:0]    m_wdata_q, m_wdata_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [DATA_W-1:0]    req_rdata_q, req_rdata_d;

    logic                 found;
    int                   sel_i;
    logic [NUM_REQ-1:0]   rv_sh;
    logic [NUM_REQ-1:0]   we_sh;

    // Round-robin search: first set request starting at last+1, wrapping.
    always_comb begin
        found = 1'b0;
        sel_i = 0;
        rv_sh = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = int'(last_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            rv_sh = req_valid >> idx;
            if (!found && rv_sh[0]) begin
                found = 1'b1;
                sel_i = idx;
            end
        end
        we_sh = req_we >> sel_i;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_id_d    = gnt_id_q;
        m_start_d   = m_start_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        req_ack_d   = '0;
        req_rdata_d = req_rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_id_d  = ID_W'(sel_i);
                    last_d    = ID_W'(sel_i);
                    m_we_d    = we_sh[0];
                    m_addr_d  = ADDR_W'(req_addr >> (sel_i * ADDR_W));
                    m_wdata_d = DATA_W'(req_wdata >> (sel_i * DATA_W));
                    m_start_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (m_done) begin
                    req_ack_d = NUM_REQ'(1) << gnt_id_q;
                    if (!m_we_q) req_rdata_d = m_rdata;
                    m_start_d = 1'b0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                if (!m_done) state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                m_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            gnt_id_q    <= '0;
            m_start_q   <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            req_ack_q   <= '0;
            req_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_id_q    <= gnt_id_d;
            m_start_q   <= m_start_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            req_ack_q   <= req_ack_d;
            req_rdata_q <= req_rdata_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign req_rdata = req_rdata_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = (state_q != IDLE);
    assign m_start   = m_start_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Directed bench for axi_lite_cmd_arbiter: reads, writes, round-robin order, slow release, mid-transaction reset.
module tb_axi_lite_cmd_arbiter;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_we = '0;
    logic [127:0]  req_addr = '0;
    logic [127:0]  req_wdata = '0;
    logic [3:0]    req_ack;
    logic [31:0]   req_rdata;
    logic [1:0]    gnt_id;
    logic          busy;
    logic          m_start;
    logic          m_we;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata = '0;
    logic          m_done = 1'b0;

    int total = 0;
    int bad = 0;

    axi_lite_cmd_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_rdata(req_rdata), .gnt_id(gnt_id), .busy(busy),
        .m_start(m_start), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_we = '0;
        m_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (m_start !== 1'b0) begin bad++; $display("FAIL rst_m_start got=%0h exp=0", m_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        total++; if (req_ack !== 4'b0) begin bad++; $display("FAIL rst_ack got=%0h exp=0", req_ack); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", req_rdata); end
        total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL rst_gnt got=%0h exp=0", gnt_id); end
        total++; if ({m_we, m_addr, m_wdata} !== 65'h0) begin bad++; $display("FAIL rst_mfields got=%0h exp=0", {m_we, m_addr, m_wdata}); end
    endtask

    task automatic test_read();
        req_addr[31:0] = 32'h0000_0010;
        req_we[0] = 1'b0;
        req_valid = 4'b0001;
        #1;
        total++; if (m_start !== 1'b0) begin bad++; $display("FAIL read_no_start_yet got=%0h exp=0", m_start); end
        tick();
        total++; if (m_start !== 1'b1) begin bad++; $display("FAIL read_start got=%0h exp=1", m_start); end
        total++; if (m_addr !== 32'h10) begin bad++; $display("FAIL read_addr got=%0h exp=10", m_addr); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL read_we got=%0h exp=0", m_we); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy got=%0h exp=1", busy); end
        m_rdata = 32'hDEAD_BEEF;
        m_done = 1'b1;
        tick();
        total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL read_ack got=%0h exp=1", req_ack); end
        total++; if (req_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_rdata got=%0h exp=deadbeef", req_rdata); end
        total++; if (m_start !== 1'b0) begin bad++; $display("FAIL read_start_drop got=%0h exp=0", m_start); end
        req_valid = 4'b0000;
        m_done = 1'b0;
        tick();
        total++; if (req_ack !== 4'b0000) begin bad++; $display("FAIL read_ack_1cyc got=%0h exp=0", req_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_idle got=%0h exp=0", busy); end
    endtask

    task automatic test_write();
        req_we[2] = 1'b1;
        req_addr[95:64] = 32'h0000_0020;
        req_wdata[95:64] = 32'hA5A5_0001;
        req_valid = 4'b0100;
        tick();
        total++; if (m_start !== 1'b1) begin bad++; $display("FAIL wr_start got=%0h exp=1", m_start); end
        total++; if (m_we !== 1'b1) begin bad++; $display("FAIL wr_we got=%0h exp=1", m_we); end
        total++; if (m_wdata !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_wdata got=%0h exp=a5a50001", m_wdata); end
        total++; if (m_addr !== 32'h20) begin bad++; $display("FAIL wr_addr got=%0h exp=20", m_addr); end
        total++; if (gnt_id !== 2'd2) begin bad++; $display("FAIL wr_gnt got=%0h exp=2", gnt_id); end
        m_rdata = 32'h1234_5678;
        m_done = 1'b1;
        tick();
        total++; if (req_ack !== 4'b0100) begin bad++; $display("FAIL wr_ack got=%0h exp=4", req_ack); end
        total++; if (req_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rdata_hold got=%0h exp=deadbeef", req_rdata); end
        req_valid = 4'b0000;
        req_we[2] = 1'b0;
        m_done = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 4'b0101;
        tick();
        total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL sim_gnt0 got=%0h exp=0", gnt_id); end
        m_done = 1'b1;
        tick();
        total++; if (req_ack !== 4'b0001) begin bad++; $display("FAIL sim_ack0 got=%0h exp=1", req_ack); end
        req_valid = 4'b0100;
        m_done = 1'b0;
        tick();
        total++; if (m_start !== 1'b0) begin bad++; $display("FAIL sim_gap got=%0h exp=0", m_start); end
        tick();
        total++; if (gnt_id !== 2'd2 || m_start !== 1'b1) begin bad++; $display("FAIL sim_gnt2 got=%0h/%0h exp=2/1", gnt_id, m_start); end
        m_done = 1'b1;
        tick();
        total++; if (req_ack !== 4'b0100) begin bad++; $display("FAIL sim_ack2 got=%0h exp=4", req_ack); end
        req_valid = 4'b0000;
        m_done = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        logic [1:0] prev_id;
        do_reset();
        for (int r = 0; r < 4; r++) req_addr[r*32 +: 32] = 32'h100 + 32'(r * 4);
        req_we = 4'b0000;
        req_valid = 4'b1111;
        prev_id = 2'd3;
        for (int k = 0; k < 8; k++) begin
            exp_id = 2'(k % 4);
            tick();
            total++; if (gnt_id !== exp_id || m_start !== 1'b1) begin bad++; $display("FAIL rr_gnt k=%0d got=%0h exp=%0h", k, gnt_id, exp_id); end
            total++; if (gnt_id === prev_id) begin bad++; $display("FAIL rr_repeat k=%0d got=%0h prev=%0h", k, gnt_id, prev_id); end
            total++; if (m_addr !== 32'h100 + 32'(exp_id) * 4) begin bad++; $display("FAIL rr_addr k=%0d got=%0h", k, m_addr); end
            prev_id = gnt_id;
            m_done = 1'b1;
            tick();
            total++; if (req_ack !== (4'b0001 << exp_id)) begin bad++; $display("FAIL rr_ack k=%0d got=%0h exp=%0h", k, req_ack, 4'b0001 << exp_id); end
            m_done = 1'b0;
            tick();
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_slow_release();
        do_reset();
        req_valid = 4'b0010;
        tick();
        total++; if (gnt_id !== 2'd1) begin bad++; $display("FAIL slow_gnt1 got=%0h exp=1", gnt_id); end
        m_done = 1'b1;
        tick();
        total++; if (req_ack !== 4'b0010) begin bad++; $display("FAIL slow_ack got=%0h exp=2", req_ack); end
        req_valid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (m_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL slow_hold c=%0d start=%0h busy=%0h exp=0/1", c, m_start, busy); end
        end
        m_done = 1'b0;
        tick();
        total++; if (m_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL slow_idle start=%0h busy=%0h exp=0/0", m_start, busy); end
        tick();
        total++; if (m_start !== 1'b1 || gnt_id !== 2'd3) begin bad++; $display("FAIL slow_regrant start=%0h gnt=%0h exp=1/3", m_start, gnt_id); end
        m_done = 1'b1;
        tick();
        req_valid = 4'b0000;
        m_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0001;
        tick();
        m_done = 1'b1;
        tick();
        req_valid = 4'b0000;
        m_done = 1'b0;
        tick();
        req_valid = 4'b0001;
        tick();
        total++; if (m_start !== 1'b1) begin bad++; $display("FAIL mid_issue got=%0h exp=1", m_start); end
        m_done = 1'b1;
        rst = 1'b1;
        #1;
        total++; if (m_start !== 1'b0 || req_ack !== 4'b0) begin bad++; $display("FAIL mid_rst start=%0h ack=%0h exp=0/0", m_start, req_ack); end
        tick();
        total++; if (req_ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_hold ack=%0h busy=%0h exp=0/0", req_ack, busy); end
        m_done = 1'b0;
        req_valid = 4'b1001;
        rst = 1'b0;
        tick();
        total++; if (gnt_id !== 2'd0 || m_start !== 1'b1) begin bad++; $display("FAIL mid_ptr gnt=%0h start=%0h exp=0/1", gnt_id, m_start); end
        m_done = 1'b1;
        tick();
        req_valid = 4'b0000;
        m_done = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_simultaneous();
        test_round_robin();
        test_slow_release();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
